// File: rtl/msg_pkg.sv
// msg_pkg: shared FSM state encoding and default idle word for message_queue
package msg_pkg;
   typedef enum logic [1:0] {
      IDLE     = 2'b00,
      WAIT     = 2'b01,
      TRANSMIT = 2'b11
   } state_t;
   localparam logic [63:0] DEFAULT_IDLE_WORD = '1;
endpackage

// File: rtl/msg_fifo.sv
// msg_fifo: circular word store with wrapping pointers, registered count and overflow pulse
module msg_fifo #(
   parameter int DATA_W = 8,
   parameter int DEPTH  = 4
) (
   input  logic                       clk,
   input  logic                       nRst,
   input  logic                       clear,
   input  logic                       push,
   input  logic                       pop,
   input  logic [DATA_W-1:0]          wdata,
   output logic [DATA_W-1:0]          rdata,
   output logic [$clog2(DEPTH+1)-1:0] count,
   output logic                       full,
   output logic                       empty,
   output logic                       overflow
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH+1);
   logic [DATA_W-1:0] mem [DEPTH];
   logic [AW-1:0] wptr, rptr;
   logic push_ok;
   // a pop in the same cycle frees the slot a full-queue push needs
   assign push_ok = push && (!full || pop);
   assign full = count == CW'(DEPTH);
   assign empty = count == '0;
   assign rdata = mem[rptr];
   always_ff @(posedge clk or negedge nRst) begin
      if (!nRst) begin
         wptr <= '0;
         rptr <= '0;
         count <= '0;
         overflow <= 1'b0;
      end else if (clear) begin
         wptr <= '0;
         rptr <= '0;
         count <= '0;
         overflow <= 1'b0;
      end else begin
         wptr <= wptr + AW'(push_ok);
         rptr <= rptr + AW'(pop);
         count <= count + CW'(push_ok) - CW'(pop);
         overflow <= push && !push_ok;
      end
   end
   always_ff @(posedge clk) begin
      if (push_ok && !clear)
         mem[wptr] <= wdata;
   end
endmodule

// File: rtl/message_queue.sv
// message_queue: word queue feeding a handshaked transmitter via an IDLE/WAIT/TRANSMIT FSM
module message_queue import msg_pkg::*; #(
   parameter int                DATA_W    = 8,
   parameter int                DEPTH     = 4,
   parameter logic [DATA_W-1:0] IDLE_WORD = DEFAULT_IDLE_WORD[DATA_W-1:0]
) (
   input  logic                       clk,
   input  logic                       nRst,
   input  logic                       ready,
   input  logic [DATA_W-1:0]          data,
   input  logic                       transmit_ready,
   input  logic                       clear,
   output logic [DATA_W-1:0]          tx_byte,
   output logic                       tx_ctrl,
   output logic                       blue,
   output logic [$clog2(DEPTH+1)-1:0] count,
   output logic                       full,
   output logic                       empty,
   output logic                       overflow
);
   localparam int CW = $clog2(DEPTH+1);
   state_t state, state_nxt;
   logic pop;
   logic [DATA_W-1:0] head;
   assign pop = state == TRANSMIT;
   msg_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_fifo (
      .clk(clk), .nRst(nRst), .clear(clear), .push(ready), .pop(pop),
      .wdata(data), .rdata(head), .count(count), .full(full),
      .empty(empty), .overflow(overflow)
   );
   always_ff @(posedge clk or negedge nRst) begin
      if (!nRst)
         state <= IDLE;
      else
         state <= state_nxt;
   end
   // leaving TRANSMIT: words remain if more than the popped one, or a push lands now
   always_comb begin
      state_nxt = IDLE;
      case (state)
         IDLE:     state_nxt = empty ? IDLE : WAIT;
         WAIT:     state_nxt = transmit_ready ? TRANSMIT : WAIT;
         TRANSMIT: state_nxt = (count > CW'(1) || ready) ? WAIT : IDLE;
         default:  state_nxt = IDLE;
      endcase
      if (clear)
         state_nxt = IDLE;
   end
   assign tx_ctrl = state != IDLE;
   assign blue = state == TRANSMIT;
   assign tx_byte = blue ? head : IDLE_WORD;
endmodule

// File: doc/message_queue.md
MESSAGE_QUEUE -- requirements
Module: message_queue

Interface
REQ-001 Parameter DATA_W, default 8, SHALL set the message byte/word width in bits.
REQ-002 Parameter DEPTH, default 4, SHALL set the queue entries; legal values are powers of two, 2..64.
REQ-003 Parameter IDLE_WORD, default all-ones of DATA_W, SHALL be the tx_byte value whenever no word is being sent.
REQ-004 clk  input  1  single system clock; all state SHALL change on its rising edge.
REQ-005 nRst  input  1  reset, asynchronous and active-low.
REQ-006 ready  input  1  push strobe; data is captured on a cycle where ready=1.
REQ-007 data  input  DATA_W  word to enqueue.
REQ-008 transmit_ready  input  1  downstream transmitter can accept a word this cycle.
REQ-009 clear  input  1  synchronous flush of the queue and FSM.
REQ-010 tx_byte  output  DATA_W  word presented to the transmitter.
REQ-011 tx_ctrl  output  1  transmit request to the downstream transmitter.
REQ-012 blue  output  1  indicator pulse; high for the cycle a word is sent.
REQ-013 count  output  $clog2(DEPTH+1)  number of stored words.
REQ-014 full, empty  output  1 each  count==DEPTH / count==0.
REQ-015 overflow  output  1  one-cycle pulse when a push is dropped.

Function
REQ-016 Storage SHALL be a circular FIFO with write and read pointers of $clog2(DEPTH) bits that wrap from DEPTH-1 to 0.
REQ-017 Push SHALL be accepted when ready=1 and (not full, or a pop occurs in the same cycle); the word is visible at the head no earlier than the next cycle.
REQ-018 Push while full without a same-cycle pop SHALL be dropped, leave contents unchanged, and pulse overflow=1 for one cycle.
REQ-019 The FSM SHALL have states IDLE, WAIT and TRANSMIT.
REQ-020 IDLE: tx_ctrl=0, blue=0, tx_byte=IDLE_WORD; go to WAIT on the next edge when empty=0.
REQ-021 WAIT: tx_ctrl=1, blue=0, tx_byte=IDLE_WORD; go to TRANSMIT when transmit_ready=1, otherwise stay.
REQ-022 TRANSMIT: tx_ctrl=1, blue=1, tx_byte=head word; the pop SHALL occur on this cycle's edge.
REQ-023 From TRANSMIT, the FSM SHALL go to WAIT if words remain after the pop (including one pushed the same cycle), otherwise to IDLE.
REQ-024 Steady-state latency SHALL be: push at cycle N -> WAIT at N+2 -> TRANSMIT at N+3 if transmit_ready is held high.
REQ-025 Back-to-back words SHALL be sent at most one every two cycles (WAIT/TRANSMIT alternation).
REQ-026 Simultaneous push and pop SHALL leave count unchanged and keep both words in order.
REQ-027 Pops SHALL occur only in TRANSMIT, which is only reachable with empty=0; underflow SHALL be impossible.
REQ-028 clear=1 SHALL zero pointers and count, force the FSM to IDLE, and drop any same-cycle push; clear SHALL take priority over push and pop.
REQ-029 count, full and empty SHALL be registered-consistent: all three derive from the same registered count.

Reset
REQ-030 nRst=0 SHALL immediately force: pointers=0, count=0, FSM=IDLE, empty=1, full=0, overflow=0, tx_ctrl=0, blue=0, tx_byte=IDLE_WORD.
REQ-031 Reset mid-operation SHALL discard all stored words; memory contents need not be cleared.
REQ-032 Every output SHALL be defined in every state; there SHALL be no latches and the default FSM branch SHALL return to IDLE.

Structure
REQ-033 The state enum (IDLE=2'b00, WAIT=2'b01, TRANSMIT=2'b11) SHALL live in shared package msg_pkg, replacing any file-scope typedef.
REQ-034 The default IDLE_WORD constant SHALL also live in msg_pkg.
REQ-035 Storage plus pointers/count SHALL be one sub-module, msg_fifo (DATA_W, DEPTH), instantiated once; the FSM SHALL stay in message_queue.

Verification
REQ-036 Push 8'h41 with transmit_ready=1 -> tx_ctrl=1 two cycles later; next cycle tx_byte=8'h41, blue=1; then IDLE, empty=1.
REQ-037 DEPTH=4: push 8'h01..8'h05 with transmit_ready=0 -> full=1 after four; fifth push gives overflow pulse; then drain sends 01,02,03,04 in order.
REQ-038 Hold transmit_ready=0 for 10 cycles in WAIT -> tx_ctrl stays 1, tx_byte=8'hFF, count unchanged; release -> TRANSMIT next cycle.
REQ-039 Full queue, push 8'hAA in the TRANSMIT cycle -> no overflow, count stays 4, 8'hAA is sent last; pointers wrap correctly across six words.
REQ-040 Assert nRst=0 mid-WAIT with count=3 -> outputs take reset values asynchronously; after release, empty=1 and nothing is transmitted.
REQ-041 clear=1 together with ready=1 and a TRANSMIT pop -> count=0, FSM=IDLE next cycle, and no word is sent afterwards.
